// File: rtl/low_freq_pulse_gen.sv
// low_freq_pulse_gen
// Programmable low-frequency pulse generator. A start request carries a target
// frequency in mHz. A restoring divider (one quotient bit per cycle) turns it
// into a period P = CLK_FREQ*1000 / f in clock cycles. The block then emits
// single-cycle pulses on o_signal every P cycles, either a counted number or
// continuously until stopped.
//
// Build option: define LOW_FREQ_PULSE_GEN_ROUND_EN to round the period to the
// nearest integer (f/2 is added to the dividend). When it is not defined the
// period is truncated. Latency is the same in both builds.
//
// Ports:
//   i_clk        clock
//   i_rst        synchronous reset, active high
//   i_start      start request, honoured only while o_ready=1
//   i_frequency  target frequency in mHz, sampled with i_start
//   i_pulses     pulse count, sampled with i_start (0 = continuous)
//   i_stop       abort while dividing or running
//   o_signal     registered pulse output, one cycle high per period
//   o_period     computed period in cycles
//   o_ready      high while idle
//   o_done       one-cycle pulse after the last pulse of a finite train
//   o_err        one-cycle pulse on an out-of-range frequency
module low_freq_pulse_gen #(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned F_MIN    = 1_000,
  parameter int unsigned F_MAX    = 1_000_000_000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [31:0] i_frequency,
  input  logic [15:0] i_pulses,
  input  logic        i_stop,
  output logic        o_signal,
  output logic [31:0] o_period,
  output logic        o_ready,
  output logic        o_done,
  output logic        o_err
);

  localparam logic [63:0] DIVIDEND = 64'(CLK_FREQ) * 64'd1000;
  // Wide enough for the dividend plus the rounding term; 37 at default.
  localparam int DW = $clog2(DIVIDEND + 64'(F_MAX));

  typedef enum logic [2:0] {IDLE, DIV, RUN, DONE, ERR} state_t;

  state_t      state;
  logic [DW-1:0] quo;        // dividend bits shift out the top, quotient bits in at the bottom
  logic [31:0] rem;
  logic [31:0] divisor;
  logic [6:0]  iter;
  logic [15:0] pulse_target;
  logic [15:0] pulse_cnt;
  logic [31:0] pcnt;         // period counter value of the current RUN cycle

  logic [32:0]   trial;
  logic [32:0]   diff;
  logic          take;
  logic [31:0]   next_rem;
  logic [DW-1:0] next_quo;
  logic [DW-1:0] load_val;
  logic [31:0]   pnext;
  logic          out_of_range;

  always_comb begin
    trial    = {rem, quo[DW-1]};
    diff     = trial - {1'b0, divisor};
    take     = ~diff[32];
    // When the subtraction is skipped, trial < divisor, so it fits 32 bits.
    next_rem = take ? diff[31:0] : trial[31:0];
    next_quo = {quo[DW-2:0], take};
`ifdef LOW_FREQ_PULSE_GEN_ROUND_EN
    load_val = DW'(DIVIDEND) + DW'({1'b0, i_frequency[31:1]});
`else
    load_val = DW'(DIVIDEND);
`endif
    pnext        = (pcnt == o_period - 32'd1) ? 32'd0 : pcnt + 32'd1;
    out_of_range = (i_frequency < F_MIN) || (i_frequency > F_MAX);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= IDLE;
      o_signal     <= 1'b0;
      o_period     <= '0;
      o_ready      <= 1'b1;
      o_done       <= 1'b0;
      o_err        <= 1'b0;
      quo          <= '0;
      rem          <= '0;
      divisor      <= '0;
      iter         <= '0;
      pulse_target <= '0;
      pulse_cnt    <= '0;
      pcnt         <= '0;
    end else begin
      o_done <= 1'b0;
      o_err  <= 1'b0;
      case (state)
        IDLE: begin
          // Start beats a simultaneous stop here since stop is only looked at later.
          if (i_start) begin
            o_ready <= 1'b0;
            if (out_of_range) begin
              state <= ERR;
              o_err <= 1'b1;
            end else begin
              state        <= DIV;
              divisor      <= i_frequency;
              pulse_target <= i_pulses;
              quo          <= load_val;
              rem          <= '0;
              iter         <= 7'(DW - 1);
            end
          end
        end
        DIV: begin
          if (i_stop) begin
            state   <= IDLE;
            o_ready <= 1'b1;
          end else begin
            quo  <= next_quo;
            rem  <= next_rem;
            iter <= iter - 7'd1;
            if (iter == 7'd0) begin
              // Last quotient bit: enter RUN with the first pulse already out.
              state     <= RUN;
              o_period  <= 32'(next_quo);
              o_signal  <= 1'b1;
              pcnt      <= '0;
              pulse_cnt <= 16'd1;
            end
          end
        end
        RUN: begin
          if (i_stop) begin
            state    <= IDLE;
            o_ready  <= 1'b1;
            o_signal <= 1'b0;
          end else if (o_signal && pulse_target != 16'd0 && pulse_cnt == pulse_target) begin
            // The final pulse is on the output this cycle.
            state    <= DONE;
            o_done   <= 1'b1;
            o_signal <= 1'b0;
          end else begin
            pcnt     <= pnext;
            o_signal <= (pnext == 32'd0);
            if (pnext == 32'd0) pulse_cnt <= pulse_cnt + 16'd1;
          end
        end
        DONE: begin
          state   <= IDLE;
          o_ready <= 1'b1;
        end
        ERR: begin
          state   <= IDLE;
          o_ready <= 1'b1;
        end
        default: begin
          state   <= IDLE;
          o_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/low_freq_pulse_gen.md
# low_freq_pulse_gen

Programmable low-frequency pulse generator, the transmit-side companion of `low_freq_counter_bin`. It takes a target frequency in millihertz and converts it to a period in clock cycles using an on-block sequential divider. It then emits a train of single-cycle pulses at that period. It is the stimulus source for on-board loopback with the counter, and uses the same single-cycle pulse convention and the same start/ready/done handshake.

## Interface
- `CLK_FREQ`, 100_000_000: clock frequency in Hz. Divider dividend = `CLK_FREQ` × 1000, 37 bits at default.
- `F_MIN`, 1_000: lowest accepted frequency in mHz (1 Hz).
- `F_MAX`, 1_000_000_000: highest accepted frequency in mHz (1 MHz).

Ports:
- `i_clk`  in  1: the single clock.
- `i_rst`  in  1: reset, synchronous, active-high.
- `i_start`  in  1: start request; honoured only while `o_ready`=1.
- `i_frequency`  in  32: target frequency in mHz, sampled with `i_start`.
- `i_pulses`  in  16: number of pulses to emit, sampled with `i_start`; 0 = continuous until `i_stop`.
- `i_stop`  in  1: abort; effective in DIV and RUN.
- `o_signal`  out  1: registered pulse output, one cycle high per period.
- `o_period`  out  32: computed period in cycles; valid from entry to RUN until the next accepted start.
- `o_ready`  out  1: high in IDLE.
- `o_done`  out  1: one-cycle pulse after the final pulse of a finite train.
- `o_err`  out  1: one-cycle pulse when `i_frequency` is out of range.

## Operation
- FSM states: IDLE, DIV, RUN, DONE, ERR.
- IDLE, on `i_start`:
  - `i_frequency` < `F_MIN` or > `F_MAX`: go to ERR.
  - Otherwise: latch the frequency and pulse count, go to DIV.
- DIV: restoring divider, one quotient bit per cycle, 37 iterations. Computes P = (`CLK_FREQ`×1000) / `i_frequency`, then goes to RUN.
  - In range, P is between 100 and 100_000_000 and fits 27 bits. `o_period` is P zero-extended.
- RUN:
  - A period counter counts 0..P−1 and wraps.
  - `o_signal` is high in every cycle where the counter is 0, so the first pulse is in the first RUN cycle.
  - A pulse counter increments on each pulse.
  - When the count reaches `i_pulses` (nonzero), go to DONE the cycle after that pulse.
  - Result: consecutive rising edges of `o_signal` are exactly P cycles apart.
- DONE: `o_done`=1 for one cycle, then IDLE.
- ERR: `o_err`=1 for one cycle, then IDLE. `o_period` is unchanged.
- `i_stop` in DIV or RUN: go to IDLE at the next edge. `o_signal` is low from that edge on; no `o_done` is issued. `i_stop` in other states is ignored.
- `i_start` outside IDLE is ignored. `i_start` and `i_stop` together in IDLE: the start wins.
- `i_pulses`=1: single pulse, then DONE.

## Timing
- Reset values: `o_signal`=0, `o_period`=0, `o_ready`=1, `o_done`=0, `o_err`=0. FSM goes to IDLE and all counters clear.
- Reset mid-operation: same reset values at the next edge; any train in progress is lost.
- With start sampled at edge S:
  - `o_ready`=0 from S+1.
  - DIV occupies cycles S+1..S+37.
  - The first `o_signal` high cycle is S+38.
  - Pulse k (from 0) is high at S+38+k·P.
- The last pulse of a finite train is high at S+38+(N−1)·P. `o_done` is high the next cycle, and `o_ready` returns the cycle after that.
- Out-of-range start at S: `o_err` high in S+1, `o_ready` high again at S+2.
- Minimum back-to-back restart: start sampled in the first `o_ready` cycle.

## Configuration
- `LOW_FREQ_PULSE_GEN_ROUND_EN` defined: round-to-nearest division. The divider adds `i_frequency`>>1 to the dividend before dividing, so P = floor((`CLK_FREQ`·1000 + f/2)/f).
- Not defined: truncating division, P = floor(`CLK_FREQ`·1000/f).
- Latency is identical in both builds.

## Test plan
- `i_frequency`=1_000_000, `i_pulses`=4 → `o_period`=100_000; 4 pulses at S+38+k·100_000; `o_done` one cycle after the 4th.
- `i_frequency`=1_000_000_000, `i_pulses`=3 → P=100.
- `i_frequency`=1_000 → P=100_000_000, checked on 2 pulses.
- `i_frequency`=6_000_000 → P=16_666 without the macro, 16_667 with `LOW_FREQ_PULSE_GEN_ROUND_EN`.
- `i_frequency`=999, then separately 1_000_000_001 → `o_err` at S+1, no `o_signal` activity, `o_ready` back at S+2. `i_start` during DIV is ignored.
- `i_pulses`=0, f=10_000_000 → continuous pulses every 10_000 cycles. Assert `i_stop` after the 5th pulse → no further pulses, no `o_done`, `o_ready` high next cycle. Repeat with `i_rst` mid-RUN → reset values.
- Loopback into `low_freq_counter_bin` with f=1_000_000 and `i_pulses`=2 → counter `o_frequency` within ±1 of 1_000_000.
